// File: rtl/srv1_mem_pkg.sv
// Shared types and constants for the memory stage.
// Contents: FSM state enum, ctr_word bit indices, access-size codes,
//           writeback operand payload struct, misalignment helper.
package srv1_mem_pkg;

    localparam int unsigned CTR_WE  = 0;
    localparam int unsigned CTR_MRD = 3;
    localparam int unsigned CTR_MWR = 4;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    // Writeback operands carried through the pipeline register.
    typedef struct packed {
        logic [2:0]  ctr;
        logic [2:0]  fn3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [29:0] inc_pc;
        logic [19:0] imm;
    } wb_op_t;

    // Half at an odd offset, or word (size codes 2 and 3) at any nonzero offset.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SZ_HALF) && offset[0]) || (size[1] && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/memory_stage_output_adj.sv
// Store-side data formatter: little-endian register value to big-endian bus lanes.
// Ports: i_store_data (rs2 value), i_size (funct3[1:0]), i_offset (byte address [1:0])
//        -> o_wdata (lane-replicated big-endian data), o_be (byte enables, [3] = offset 0).
module output_adj
    import srv1_mem_pkg::*;
(
    input  logic [31:0] i_store_data,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be
);

    logic [7:0]  w_b;
    logic [15:0] w_h;

    assign w_b = i_store_data[7:0];
    assign w_h = i_store_data[15:0];

    // Data is replicated on every lane so the enables alone select the target bytes.
    always_comb begin
        o_wdata = '0;
        o_be    = '0;
        case (i_size)
            SZ_BYTE: begin
                o_wdata = {4{w_b}};
                o_be    = 4'b1000 >> i_offset;
            end
            SZ_HALF: begin
                o_wdata = {w_h[7:0], w_h[15:8], w_h[7:0], w_h[15:8]};
                o_be    = i_offset[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                o_wdata = {i_store_data[7:0], i_store_data[15:8],
                           i_store_data[23:16], i_store_data[31:24]};
                o_be    = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: issues load/store transactions on a big-endian req/ack data bus,
// stalls execute while a transaction is outstanding, and registers writeback operands.
// Ports: clk/rst (sync active-high); execute-side inputs (valid_in, ctr_word_in, fn3_in,
//        rd_addr_in, alu_in, store_data_in, inc_pc_in, u_type_imm_in); stall_out;
//        bus_req/bus_we/bus_addr/bus_wdata/bus_be out, bus_ack/bus_rdata in;
//        writeback outputs (ctr_word_out ... u_type_imm_out).
// Optional: define MISALIGN_TRAP_EN to add misalign_exc and suppress misaligned accesses.
module memory_stage
    import srv1_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [4:0]        ctr_word_in,
    input  logic [2:0]        fn3_in,
    input  logic [4:0]        rd_addr_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       store_data_in,
    input  logic [29:0]       inc_pc_in,
    input  logic [19:0]       u_type_imm_in,
    output logic              stall_out,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic [2:0]        ctr_word_out,
    output logic [2:0]        fn3_out,
    output logic [4:0]        rd_addr_out,
    output logic [31:0]       memory_data_out,
    output logic [31:0]       alu_out,
    output logic [29:0]       inc_pc_out,
    output logic [19:0]       u_type_imm_out
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_exc
`endif
);

    state_t      r_state;
    wb_op_t      r_wb;
    logic [31:0] r_mem_data;

    logic        w_mem_op;
    logic        w_is_store;
    logic        w_misalign;
    logic        w_issue;
    logic [31:0] w_fmt_wdata;
    logic [3:0]  w_fmt_be;
    wb_op_t      w_wb_in;

    // Both mem-read and mem-write set is treated as a store.
    assign w_mem_op   = valid_in & (ctr_word_in[CTR_MRD] | ctr_word_in[CTR_MWR]);
    assign w_is_store = ctr_word_in[CTR_MWR];

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = is_misaligned(fn3_in[1:0], alu_in[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_issue = w_mem_op & ~w_misalign;

    assign w_wb_in = '{ctr:    ctr_word_in[2:0],
                       fn3:    fn3_in,
                       rd:     rd_addr_in,
                       alu:    alu_in,
                       inc_pc: inc_pc_in,
                       imm:    u_type_imm_in};

    output_adj u_output_adj (
        .i_store_data (store_data_in),
        .i_size       (fn3_in[1:0]),
        .i_offset     (alu_in[1:0]),
        .o_wdata      (w_fmt_wdata),
        .o_be         (w_fmt_be)
    );

    // Stall holds execute from the issue cycle until the ack cycle.
    always_comb begin
        stall_out = 1'b0;
        case (r_state)
            IDLE:    stall_out = w_issue;
            BUS:     stall_out = ~bus_ack;
            default: stall_out = 1'b0;
        endcase
    end

    // Bus FSM and writeback pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            r_wb       <= '0;
            r_mem_data <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_exc <= 1'b0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            misalign_exc <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        bus_req    <= 1'b1;
                        bus_we     <= w_is_store;
                        bus_addr   <= ADDR_W'(alu_in[31:2]);
                        bus_wdata  <= w_is_store ? w_fmt_wdata : 32'h0;
                        bus_be     <= w_is_store ? w_fmt_be : 4'b1111;
                        r_wb       <= '0;
                        r_mem_data <= '0;
                        r_state    <= BUS;
                    end else if (valid_in && !w_mem_op) begin
                        r_wb       <= w_wb_in;
                        r_mem_data <= '0;
                    end else begin
                        // Idle cycle or suppressed misaligned access: bubble.
                        r_wb       <= '0;
                        r_mem_data <= '0;
`ifdef MISALIGN_TRAP_EN
                        misalign_exc <= w_mem_op;
`endif
                    end
                end
                BUS: begin
                    if (bus_ack) begin
                        bus_req    <= 1'b0;
                        r_mem_data <= bus_rdata;
                        r_wb       <= w_wb_in;
                        r_state    <= IDLE;
                    end else begin
                        r_wb       <= '0;
                        r_mem_data <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ctr_word_out    = r_wb.ctr;
    assign fn3_out         = r_wb.fn3;
    assign rd_addr_out     = r_wb.rd;
    assign alu_out         = r_wb.alu;
    assign inc_pc_out      = r_wb.inc_pc;
    assign u_type_imm_out  = r_wb.imm;
    assign memory_data_out = r_mem_data;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: an execute-stage driver, a req/ack bus responder
// with per-transaction latency, and a monitor comparing bus requests and writeback
// operands against expectations computed from the byte-lane rules.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [4:0]  ctr_word_in;
    logic [2:0]  fn3_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] alu_in;
    logic [31:0] store_data_in;
    logic [29:0] inc_pc_in;
    logic [19:0] u_type_imm_in;
    logic        stall_out;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [2:0]  ctr_word_out;
    logic [2:0]  fn3_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] memory_data_out;
    logic [31:0] alu_out;
    logic [29:0] inc_pc_out;
    logic [19:0] u_type_imm_out;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_exc;
`endif

    memory_stage #(.ADDR_W(30)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in        (valid_in),
        .ctr_word_in     (ctr_word_in),
        .fn3_in          (fn3_in),
        .rd_addr_in      (rd_addr_in),
        .alu_in          (alu_in),
        .store_data_in   (store_data_in),
        .inc_pc_in       (inc_pc_in),
        .u_type_imm_in   (u_type_imm_in),
        .stall_out       (stall_out),
        .bus_req         (bus_req),
        .bus_we          (bus_we),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_be          (bus_be),
        .bus_ack         (bus_ack),
        .bus_rdata       (bus_rdata),
        .ctr_word_out    (ctr_word_out),
        .fn3_out         (fn3_out),
        .rd_addr_out     (rd_addr_out),
        .memory_data_out (memory_data_out),
        .alu_out         (alu_out),
        .inc_pc_out      (inc_pc_out),
        .u_type_imm_out  (u_type_imm_out)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_exc    (misalign_exc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctr;
        logic [2:0]  fn3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [29:0] pc;
        logic [19:0] imm;
        bit          chk_mem;
        logic [31:0] mem;
        int          due;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_exp_t;

    wb_exp_t     wb_q[$];
    bus_exp_t    bus_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          exp_trap = 0;
    int          next_lat = 0;
    logic [31:0] next_rdata = 32'h0;
    logic        prev_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Lane model: bus byte at offset k sits in bits [31-8k -: 8]; the store
    // covers 'size' bytes starting at 'base', each lane carrying the matching
    // little-endian byte of the operand.
    function automatic void fmt_store(input logic [2:0] fn3, input logic [1:0] off,
                                      input logic [31:0] d,
                                      output logic [31:0] wd, output logic [3:0] be);
        int size;
        int base;
        int idx;
        size = (fn3[1:0] == 2'd0) ? 1 : ((fn3[1:0] == 2'd1) ? 2 : 4);
        base = (size == 1) ? int'(off) : ((size == 2) ? (int'(off) & 2) : 0);
        wd = '0;
        be = '0;
        for (int k = 0; k < 4; k++) begin
            idx = (size == 4) ? k : ((size == 2) ? (k % 2) : 0);
            wd[31-8*k -: 8] = d[8*idx +: 8];
            be[3-k] = (k >= base) && (k < base + size);
        end
    endfunction

    function automatic bit misaligned(input logic [2:0] fn3, input logic [1:0] off);
        if (fn3[1:0] == 2'd1) return off[0];
        if (fn3[1]) return off != 2'd0;
        return 1'b0;
    endfunction

    // Bus responder: ack 'next_lat' cycles after req first appears.
    initial begin
        bit in_txn;
        int wcnt;
        in_txn = 0;
        wcnt = 0;
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            if (bus_req !== 1'b1) begin
                in_txn = 0;
            end else begin
                if (!in_txn) begin
                    in_txn = 1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
                if (wcnt == next_lat) begin
                    bus_ack = 1'b1;
                    bus_rdata = next_rdata;
                end
            end
        end
    end

    // Monitor: bus requests on their first cycle, writeback on every non-bubble cycle.
    always @(negedge clk) begin
        wb_exp_t  e;
        bus_exp_t b;
        if (rst === 1'b0) begin
            if (ctr_word_out != 3'd0) begin
                if (wb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wb_unexpected: got ctr %b alu %h expected no operand", ctr_word_out, alu_out);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_cycle", 32'(cyc), 32'(e.due));
                    check("wb_ctr", 32'(ctr_word_out), 32'(e.ctr));
                    check("wb_fn3", 32'(fn3_out), 32'(e.fn3));
                    check("wb_rd", 32'(rd_addr_out), 32'(e.rd));
                    check("wb_alu", alu_out, e.alu);
                    check("wb_pc", 32'(inc_pc_out), 32'(e.pc));
                    check("wb_imm", 32'(u_type_imm_out), 32'(e.imm));
                    if (e.chk_mem) check("wb_memdata", memory_data_out, e.mem);
                end
            end
            if (bus_req && !prev_req) begin
                if (bus_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bus_unexpected: got req addr %h expected no request", bus_addr);
                end else begin
                    b = bus_q.pop_front();
                    check("bus_we", 32'(bus_we), 32'(b.we));
                    check("bus_addr", 32'(bus_addr), 32'(b.addr));
                    check("bus_wdata", bus_wdata, b.wdata);
                    check("bus_be", 32'(bus_be), 32'(b.be));
                end
            end
`ifdef MISALIGN_TRAP_EN
            if (misalign_exc) begin
                check("misalign_bubble", 32'(ctr_word_out), 32'd0);
                check("misalign_expected", 32'(exp_trap > 0), 32'd1);
                if (exp_trap > 0) exp_trap--;
            end
`endif
        end
        prev_req = bus_req;
    end

    // Execute-stage model: present one instruction and hold it while stalled.
    task automatic run_op(input logic [4:0] ctr, input logic [2:0] fn3, input logic [31:0] alu,
                          input logic [31:0] sd, input int lat, input logic [31:0] rdata);
        bit       mem;
        bit       trap;
        bit       acc;
        logic     s;
        int       stalls;
        wb_exp_t  e;
        bus_exp_t b;
        mem = ctr[3] | ctr[4];
`ifdef MISALIGN_TRAP_EN
        trap = mem && misaligned(fn3, alu[1:0]);
`else
        trap = 0;
`endif
        next_lat      = lat;
        next_rdata    = rdata;
        valid_in      = 1'b1;
        ctr_word_in   = ctr;
        fn3_in        = fn3;
        rd_addr_in    = 5'($urandom);
        alu_in        = alu;
        store_data_in = sd;
        inc_pc_in     = 30'($urandom);
        u_type_imm_in = 20'($urandom);
        if (mem && !trap) begin
            b.we   = ctr[4];
            b.addr = alu[31:2];
            if (ctr[4]) begin
                fmt_store(fn3, alu[1:0], sd, b.wdata, b.be);
            end else begin
                b.wdata = 32'h0;
                b.be    = 4'b1111;
            end
            bus_q.push_back(b);
        end
        stalls = 0;
        acc = 0;
        for (int c = 0; c < 60 && !acc; c++) begin
            @(negedge clk);
            s = stall_out;
            if (s) stalls++;
            @(posedge clk);
            if (!s) acc = 1;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got stall still high expected release within 60 cycles");
        end
        check("stall_cycles", 32'(stalls), (mem && !trap) ? 32'(1 + lat) : 32'd0);
        #1;
        if (trap) begin
            exp_trap++;
        end else begin
            e.ctr = ctr[2:0];
            e.fn3 = fn3;
            e.rd  = rd_addr_in;
            e.alu = alu;
            e.pc  = inc_pc_in;
            e.imm = u_type_imm_in;
            e.chk_mem = ctr[3] && !ctr[4];
            e.mem = rdata;
            e.due = cyc;
            wb_q.push_back(e);
        end
        valid_in = 1'b0;
    endtask

    initial begin
        bus_exp_t b;
        logic [4:0] c;
        rst = 1'b1;
        valid_in = 1'b0;
        ctr_word_in = '0;
        fn3_in = '0;
        rd_addr_in = '0;
        alu_in = '0;
        store_data_in = '0;
        inc_pc_in = '0;
        u_type_imm_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_ctr", 32'(ctr_word_out), 32'd0);
        check("rst_alu", alu_out, 32'd0);
        check("rst_memdata", memory_data_out, 32'd0);
        check("rst_pc", 32'(inc_pc_out), 32'd0);
`ifdef MISALIGN_TRAP_EN
        check("rst_misalign", 32'(misalign_exc), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Directed cases.
        run_op(5'b00001, 3'd0, 32'h12345678, 32'h0, 0, 32'h0);
        run_op(5'b10000 | 5'b00100, 3'd0, 32'h00000103, 32'h000000AB, 1, 32'h0);
        run_op(5'b01011, 3'd2, 32'h00000200, 32'h0, 3, 32'h11223344);
        run_op(5'b10100, 3'd1, 32'h00000002, 32'h0000BEEF, 0, 32'h0);
        run_op(5'b11010, 3'd2, 32'h00000010, 32'hA1B2C3D4, 2, 32'h0);
        run_op(5'b01011, 3'd2, 32'h00000201, 32'h0, 0, 32'hCAFEF00D);
        run_op(5'b01011, 3'd5, 32'h00000023, 32'h0, 0, 32'h55AA55AA);

        // Reset while a load is outstanding and unacknowledged.
        next_lat = 1000;
        b.we = 1'b0;
        b.addr = 30'h000000C0;
        b.wdata = 32'h0;
        b.be = 4'b1111;
        bus_q.push_back(b);
        valid_in = 1'b1;
        ctr_word_in = 5'b01011;
        fn3_in = 3'd2;
        alu_in = 32'h00000300;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midbus_rst_req", 32'(bus_req), 32'd0);
        check("midbus_rst_ctr", 32'(ctr_word_out), 32'd0);
        check("midbus_rst_alu", alu_out, 32'd0);
        check("midbus_rst_memdata", memory_data_out, 32'd0);
        check("midbus_rst_stall", 32'(stall_out), 32'd0);
        @(posedge clk);
        #1;
        run_op(5'b01011, 3'd2, 32'h00000400, 32'h0, 1, 32'h9ABCDEF0);

        // Randomised mix of ALU ops, loads and stores with random gaps.
        for (int i = 0; i < 200; i++) begin
            c[2:0] = 3'($urandom_range(1, 7));
            c[4:3] = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            run_op(c, 3'($urandom), $urandom, $urandom, $urandom_range(0, 4), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("trap_pulses_seen", 32'(exp_trap), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Sits between the execute stage and the writeback stage.
- Issues load/store transactions on the single-port big-endian data bus, using a req/ack handshake, and stalls upstream while a transaction is outstanding.
- Registers all writeback operands into the pipeline register.
- Formats store data and byte enables little-to-big endian; raw big-endian load data is forwarded for writeback to adjust.

Parameters:
- ADDR_W, 30, word-address width of the data bus (byte address bits [31:2]).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- valid_in  input  1  execute output holds an instruction
- ctr_word_in  input  5  [0] regfile we, [2:1] writeback select, [3] mem read, [4] mem write
- fn3_in  input  3  funct3 (size [1:0], unsigned [2])
- rd_addr_in  input  5  destination register
- alu_in  input  32  ALU result / effective byte address
- store_data_in  input  32  rs2 value, little-endian
- inc_pc_in  input  30  PC+4 word address
- u_type_imm_in  input  20  U-type immediate
- stall_out  output  1  hold execute outputs stable this cycle
- bus_req  output  1  transaction request
- bus_we  output  1  1 = store
- bus_addr  output  ADDR_W  word address
- bus_wdata  output  32  big-endian store data
- bus_be  output  4  byte enables, [3] = byte at offset 0 (bits 31:24)
- bus_ack  input  1  transaction complete; rdata valid same cycle
- bus_rdata  input  32  big-endian load data
- ctr_word_out, fn3_out, rd_addr_out, memory_data_out, alu_out, inc_pc_out, u_type_imm_out  output  3/3/5/32/32/30/20  writeback operands (ctr_word_out = ctr_word_in[2:0])

Behaviour:
- Reset:
  - State IDLE.
  - bus_req, bus_we, bus_addr, bus_wdata, bus_be are 0.
  - All writeback outputs are 0 (ctr_word_out=0 is a bubble).
  - stall_out is 0 after reset.
- mem_op = valid_in & (ctr[3] | ctr[4]). If both [3] and [4] are set, the instruction is treated as a store.
- FSM states:
  - IDLE:
    - If valid_in & ~mem_op: load pipeline register from inputs next edge (latency 1).
    - If ~valid_in: load a bubble (all writeback outputs 0).
    - If mem_op: stall_out=1 combinationally. Next edge: bus_req<=1, latch bus_we, bus_addr=alu_in[31:2], bus_wdata, bus_be; load a bubble; go to BUS.
  - BUS:
    - bus_req and latched bus signals are held.
    - stall_out = ~bus_ack.
    - On the bus_ack edge:
      - bus_req<=0.
      - memory_data_out<=bus_rdata (stores: bus_rdata captured anyway, don't care).
      - Pipeline register loads the held inputs.
      - Go to IDLE.
    - Without ack: keep loading bubbles.
- Minimum memory latency: issue cycle N, bus_req high N+1, ack at N+1 gives writeback operands at N+2.
- bus_ack while in IDLE is ignored.
- Store formatting (offset = alu_in[1:0]; b = store_data_in[7:0], h = store_data_in[15:0]):
  - Byte (fn3[1:0]=0): wdata = {4{b}}; be = 4'b1000 >> offset.
  - Half (fn3[1:0]=1): wdata = {h[7:0],h[15:8],h[7:0],h[15:8]}; be = offset[1] ? 0011 : 1100.
  - Word (fn3[1:0]=2,3): wdata = byte-reversed store_data_in; be = 1111.
- Loads: bus_be=1111, bus_wdata=0.
- Reset mid-BUS:
  - bus_req drops next edge and the FSM returns to IDLE.
  - The bus must tolerate the abandoned request.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_exc (1 bit, reset 0).
  - Misaligned accesses are half with offset[0]=1, or word with offset≠0.
  - A misaligned access issues no bus transaction and no stall.
  - Writeback gets a bubble next edge; misalign_exc=1 for exactly that cycle.
- Undefined:
  - No port.
  - Offset bits are ignored for alignment (half uses offset[1] only; word uses offset 0) and the access proceeds normally.

Decomposition:
- Package srv1_mem_pkg:
  - state enum {IDLE, BUS}
  - ctr_word bit-index constants (CTR_WE, CTR_MRD, CTR_MWR)
  - size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2
- Sub-module output_adj: combinational store formatter (store_data, fn3, offset → wdata, be); mirror of the load-side adjuster.

Test Plan:
- ALU op, ctr=5'b00001, alu_in=0x12345678 → next cycle alu_out=0x12345678, ctr_word_out=3'b001, stall_out never high.
- Byte store fn3=0, alu_in=0x103, data=0xAB, ack one cycle after req → bus_addr=0x40, be=0001, wdata=0xABABABAB, we=1; stall high 2 cycles; bubble, then store fields.
- Word load fn3=2, alu_in=0x200, ack after 3 wait cycles, rdata=0x11223344 → bus_req high 4 cycles, stall 4 cycles, memory_data_out=0x11223344, ctr_word_out[2:1]=1.
- Half store fn3=1, alu_in=0x2, data=0xBEEF → be=0011, wdata=0xEFBEEFBE.
- rst asserted during BUS with no ack → bus_req=0 and all writeback outputs 0 after the edge; a new load issues normally.
- MISALIGN_TRAP_EN defined: word load alu_in=0x201 → bus_req stays 0, misalign_exc one-cycle pulse, ctr_word_out=0; undefined: access issues at bus_addr=0x80.
